// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: register map, ctrl bits, reset values and month-length helper for the RTC bus responder
package rtc_bus_pkg;
  typedef logic [7:0] bcd_t;
  localparam bcd_t ADDR_CTRL  = 8'h00;
  localparam bcd_t ADDR_SEC   = 8'h21;
  localparam bcd_t ADDR_MIN   = 8'h22;
  localparam bcd_t ADDR_HOUR  = 8'h23;
  localparam bcd_t ADDR_DAY   = 8'h24;
  localparam bcd_t ADDR_MONTH = 8'h25;
  localparam bcd_t ADDR_YEAR  = 8'h26;
  localparam bcd_t ADDR_TMR_S = 8'h41;
  localparam bcd_t ADDR_TMR_M = 8'h42;
  localparam bcd_t ADDR_TMR_H = 8'h43;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_FLAG = 2;
  localparam bcd_t RST_TIME = 8'h00;
  localparam bcd_t RST_DATE = 8'h01;
  function automatic bcd_t month_len(input bcd_t m, input logic leap);
    case (m)
      8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: month_len = 8'h31;
      8'h02: month_len = leap ? 8'h29 : 8'h28;
      default: month_len = 8'h30;
    endcase
  endfunction
endpackage

// File: rtl/rtc_bus_responder_if.sv
// rtc_bus_responder_if: RTC bus strobes driven by the clock controller
interface rtc_bus_responder_if;
  logic AD, CS, RD, RW;
  modport master(output AD, CS, RD, RW);
  modport slave(input AD, CS, RD, RW);
endinterface

// File: rtl/rtc_bcd_field.sv
// rtc_bcd_field: one BCD register with load, wrapping inc/dec between min and max, and carry/borrow out
module rtc_bcd_field import rtc_bus_pkg::*; #(
  parameter bcd_t RST = 8'h00
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic dec,
  input  bcd_t din,
  input  bcd_t min,
  input  bcd_t max,
  output bcd_t q,
  output logic co
);
  logic valid, wrap_inc, wrap_dec;
  bcd_t q_inc, q_dec;
  // non-BCD or out-of-range contents wrap on their next step, as if at the limit
  assign valid = q[3:0] <= 4'd9 && q[7:4] <= 4'd9 && q >= min && q <= max;
  assign wrap_inc = !valid || q == max;
  assign wrap_dec = !valid || q == min;
  assign q_inc = q[3:0] == 4'd9 ? {q[7:4] + 4'd1, 4'd0} : q + 8'd1;
  assign q_dec = q[3:0] == 4'd0 ? {q[7:4] - 4'd1, 4'd9} : q - 8'd1;
  assign co = (inc && wrap_inc) || (dec && wrap_dec);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= RST;
    else if (load) q <= din;
    else if (inc) q <= wrap_inc ? min : q_inc;
    else if (dec) q <= wrap_dec ? max : q_dec;
endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: RTC bus slave with BCD date/time, countdown timer and active-low timer IRQ
module rtc_bus_responder import rtc_bus_pkg::*; #(
  parameter int TICK_CYCLES = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  rtc_bus_responder_if.slave bus,
  inout  wire [7:0] Dato_sal,
  output logic IRQ,
  output logic tick
);
  localparam int CW = $clog2(TICK_CYCLES);
  logic [SYNC_STAGES-1:0] ad_s, cs_s, rd_s, rw_s;
  logic [SYNC_STAGES-1:0][7:0] dat_s;
  logic [CW-1:0] cnt;
  logic ad_f, cs_f, rd_f, rw_f, rw_q, wr, aw, upd, pend, dec_en, set, ctrl_wr, leap, drive, en, flag;
  bcd_t d_f, addr, rdata, sec_q, min_q, hour_q, day_q, mon_q, yr_q, ts_q, tm_q, th_q;
  logic sec_co, min_co, hour_co, day_co, mon_co, yr_co, ts_co, tm_co, th_co, unused_co;
  assign {ad_f, cs_f, rd_f, rw_f} = {ad_s[SYNC_STAGES-1], cs_s[SYNC_STAGES-1], rd_s[SYNC_STAGES-1], rw_s[SYNC_STAGES-1]};
  assign d_f = dat_s[SYNC_STAGES-1];
  assign aw = rw_f && !rw_q && !cs_f && !ad_f;
  assign wr = rw_f && !rw_q && !cs_f && ad_f;
  // a tick landing on a data write is replayed the next cycle against the written values
  assign upd = (tick || pend) && !wr;
  assign dec_en = upd && en && |{th_q, tm_q, ts_q};
  assign set = dec_en && {th_q, tm_q, ts_q} == 24'h000001;
  assign ctrl_wr = wr && addr == ADDR_CTRL;
  assign leap = 2'({yr_q[4], 1'b0} + yr_q[1:0]) == 2'd0;
  assign IRQ = !flag;
  assign Dato_sal = drive ? rdata : 'z;
  assign unused_co = yr_co ^ th_co;
  always_comb
    case (addr)
      ADDR_CTRL:  rdata = {5'b0, flag, 1'b0, en};
      ADDR_SEC:   rdata = sec_q;
      ADDR_MIN:   rdata = min_q;
      ADDR_HOUR:  rdata = hour_q;
      ADDR_DAY:   rdata = day_q;
      ADDR_MONTH: rdata = mon_q;
      ADDR_YEAR:  rdata = yr_q;
      ADDR_TMR_S: rdata = ts_q;
      ADDR_TMR_M: rdata = tm_q;
      ADDR_TMR_H: rdata = th_q;
      default:    rdata = 8'h00;
    endcase
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ad_s <= '0;
      cs_s <= '1;
      rd_s <= '1;
      rw_s <= '1;
      dat_s <= '0;
      rw_q <= 1'b1;
      drive <= 1'b0;
      addr <= '0;
      cnt <= '0;
      tick <= 1'b0;
      pend <= 1'b0;
      en <= 1'b0;
      flag <= 1'b0;
    end else begin
      ad_s <= SYNC_STAGES'({ad_s, bus.AD});
      cs_s <= SYNC_STAGES'({cs_s, bus.CS});
      rd_s <= SYNC_STAGES'({rd_s, bus.RD});
      rw_s <= SYNC_STAGES'({rw_s, bus.RW});
      dat_s <= (SYNC_STAGES*8)'({dat_s, Dato_sal});
      rw_q <= rw_f;
      drive <= !cs_f && ad_f && !rd_f && rw_f;
      if (aw) addr <= d_f;
      tick <= cnt == CW'(TICK_CYCLES - 1);
      cnt <= cnt == CW'(TICK_CYCLES - 1) ? '0 : cnt + 1'b1;
      pend <= (tick || pend) && wr;
      if (ctrl_wr) en <= d_f[CTRL_EN];
      flag <= set || (flag && !(ctrl_wr && !d_f[CTRL_FLAG]));
    end
  rtc_bcd_field #(RST_TIME) u_sec (.clk, .reset, .load(wr && addr == ADDR_SEC), .inc(upd), .dec(1'b0),
    .din(d_f), .min(8'h00), .max(8'h59), .q(sec_q), .co(sec_co));
  rtc_bcd_field #(RST_TIME) u_min (.clk, .reset, .load(wr && addr == ADDR_MIN), .inc(sec_co), .dec(1'b0),
    .din(d_f), .min(8'h00), .max(8'h59), .q(min_q), .co(min_co));
  rtc_bcd_field #(RST_TIME) u_hour (.clk, .reset, .load(wr && addr == ADDR_HOUR), .inc(min_co), .dec(1'b0),
    .din(d_f), .min(8'h00), .max(8'h23), .q(hour_q), .co(hour_co));
  rtc_bcd_field #(RST_DATE) u_day (.clk, .reset, .load(wr && addr == ADDR_DAY), .inc(hour_co), .dec(1'b0),
    .din(d_f), .min(8'h01), .max(month_len(mon_q, leap)), .q(day_q), .co(day_co));
  rtc_bcd_field #(RST_DATE) u_mon (.clk, .reset, .load(wr && addr == ADDR_MONTH), .inc(day_co), .dec(1'b0),
    .din(d_f), .min(8'h01), .max(8'h12), .q(mon_q), .co(mon_co));
  rtc_bcd_field #(RST_TIME) u_yr (.clk, .reset, .load(wr && addr == ADDR_YEAR), .inc(mon_co), .dec(1'b0),
    .din(d_f), .min(8'h00), .max(8'h99), .q(yr_q), .co(yr_co));
  rtc_bcd_field #(RST_TIME) u_ts (.clk, .reset, .load(wr && addr == ADDR_TMR_S), .inc(1'b0), .dec(dec_en),
    .din(d_f), .min(8'h00), .max(8'h59), .q(ts_q), .co(ts_co));
  rtc_bcd_field #(RST_TIME) u_tm (.clk, .reset, .load(wr && addr == ADDR_TMR_M), .inc(1'b0), .dec(ts_co),
    .din(d_f), .min(8'h00), .max(8'h59), .q(tm_q), .co(tm_co));
  rtc_bcd_field #(RST_TIME) u_th (.clk, .reset, .load(wr && addr == ADDR_TMR_H), .inc(1'b0), .dec(tm_co),
    .din(d_f), .min(8'h00), .max(8'h99), .q(th_q), .co(th_co));
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: directed bus transactions against hand-computed register values
module tb_rtc_bus_responder;
  import rtc_bus_pkg::*;
  localparam int TICK = 400;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h00;
  logic [7:0] rd;
  logic IRQ, tick;
  wire [7:0] dato;
  int n_tests = 0;
  int n_fail = 0;
  rtc_bus_responder_if bus();
  assign dato = tb_drv ? tb_val : 8'hzz;
  rtc_bus_responder #(.TICK_CYCLES(TICK), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .Dato_sal(dato), .IRQ(IRQ), .tick(tick));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic addr_phase(input logic [7:0] a);
    bus.CS = 1'b0; bus.AD = 1'b0; tb_val = a; tb_drv = 1'b1; bus.RW = 1'b0;
    cyc(4);
    bus.RW = 1'b1;
    cyc(4);
  endtask
  task automatic end_cycle();
    tb_drv = 1'b0; bus.CS = 1'b1; bus.AD = 1'b0; bus.RD = 1'b1; bus.RW = 1'b1;
    cyc(4);
  endtask
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    bus.AD = 1'b1; tb_val = d; bus.RW = 1'b0;
    cyc(4);
    bus.RW = 1'b1;
    cyc(4);
    end_cycle();
  endtask
  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    addr_phase(a);
    tb_drv = 1'b0; bus.AD = 1'b1;
    cyc(1);
    bus.RD = 1'b0;
    cyc(4);
    d = dato;
    bus.RD = 1'b1;
    cyc(4);
    end_cycle();
    check(tag, d, exp);
  endtask
  task automatic wait_tick();
    int n = 0;
    cyc(1);
    while (!tick && n < 2 * TICK) begin
      cyc(1);
      n++;
    end
    if (!tick) check("tick_timeout", tick, 1'b1);
  endtask
  task automatic set_dt(input logic [7:0] y, mo, d, h, mi, s);
    bus_write(ADDR_YEAR, y);
    bus_write(ADDR_MONTH, mo);
    bus_write(ADDR_DAY, d);
    bus_write(ADDR_HOUR, h);
    bus_write(ADDR_MIN, mi);
    bus_write(ADDR_SEC, s);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.AD = 1'b0; bus.CS = 1'b1; bus.RD = 1'b1; bus.RW = 1'b1;
    cyc(3);
    check("rst_drive", dut.drive, 1'b0);
    check("rst_irq", IRQ, 1'b1);
    check("rst_tick", tick, 1'b0);
    reset = 1'b1;
    cyc(2);
    // write then read with strobe-to-drive latency
    bus_write(ADDR_MIN, 8'h45);
    addr_phase(ADDR_MIN);
    tb_drv = 1'b0; bus.AD = 1'b1;
    cyc(1);
    bus.RD = 1'b0;
    cyc(2);
    check("rd_lat_off", dut.drive, 1'b0);
    cyc(1);
    check("rd_lat_on", dut.drive, 1'b1);
    check("rd_data", dato, 8'h45);
    bus.RD = 1'b1;
    cyc(2);
    check("rd_hold", dut.drive, 1'b1);
    cyc(1);
    check("rd_release", dut.drive, 1'b0);
    end_cycle();
    check("irq_idle", IRQ, 1'b1);
    bus_write(8'h7F, 8'hAA);
    read_chk("unmapped", 8'h7F, 8'h00);
    // full rollover, aligned so no tick lands during setup or readback
    wait_tick();
    set_dt(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    wait_tick();
    cyc(2);
    read_chk("roll_sec", ADDR_SEC, 8'h00);
    read_chk("roll_min", ADDR_MIN, 8'h00);
    read_chk("roll_hour", ADDR_HOUR, 8'h00);
    read_chk("roll_day", ADDR_DAY, 8'h01);
    read_chk("roll_mon", ADDR_MONTH, 8'h01);
    read_chk("roll_year", ADDR_YEAR, 8'h00);
    wait_tick();
    set_dt(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    wait_tick();
    cyc(2);
    read_chk("leap_day", ADDR_DAY, 8'h29);
    read_chk("leap_mon", ADDR_MONTH, 8'h02);
    wait_tick();
    set_dt(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    wait_tick();
    cyc(2);
    read_chk("nonleap_day", ADDR_DAY, 8'h01);
    read_chk("nonleap_mon", ADDR_MONTH, 8'h03);
    // sec write of a non-BCD value collides with a tick
    bus_write(ADDR_SEC, 8'h00);
    bus_write(ADDR_MIN, 8'h10);
    addr_phase(ADDR_SEC);
    bus.AD = 1'b1; tb_val = 8'h5A; bus.RW = 1'b0;
    wait_tick();
    cyc(TICK - 2);
    bus.RW = 1'b1;
    cyc(4);
    end_cycle();
    read_chk("coll_sec", ADDR_SEC, 8'h00);
    read_chk("coll_min", ADDR_MIN, 8'h11);
    // countdown timer 00:00:03
    wait_tick();
    bus_write(ADDR_TMR_H, 8'h00);
    bus_write(ADDR_TMR_M, 8'h00);
    bus_write(ADDR_TMR_S, 8'h03);
    bus_write(ADDR_CTRL, 8'h01);
    wait_tick();
    cyc(1);
    check("tmr_irq_t1", IRQ, 1'b1);
    wait_tick();
    cyc(1);
    check("tmr_irq_t2", IRQ, 1'b1);
    wait_tick();
    cyc(1);
    check("tmr_irq_t3", IRQ, 1'b0);
    read_chk("tmr_ctrl", ADDR_CTRL, 8'h05);
    read_chk("tmr_sec", ADDR_TMR_S, 8'h00);
    bus_write(ADDR_CTRL, 8'h01);
    check("tmr_irq_clr", IRQ, 1'b1);
    wait_tick();
    cyc(1);
    check("tmr_irq_hold", IRQ, 1'b1);
    // reset while the responder is driving the bus
    addr_phase(ADDR_MIN);
    tb_drv = 1'b0; bus.AD = 1'b1;
    cyc(1);
    bus.RD = 1'b0;
    cyc(4);
    check("mid_drive", dut.drive, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_release", dut.drive, 1'b0);
    check("mid_irq", IRQ, 1'b1);
    check("mid_tick", tick, 1'b0);
    end_cycle();
    reset = 1'b1;
    cyc(2);
    read_chk("rst_sec", ADDR_SEC, 8'h00);
    read_chk("rst_min", ADDR_MIN, 8'h00);
    read_chk("rst_hour", ADDR_HOUR, 8'h00);
    read_chk("rst_day", ADDR_DAY, 8'h01);
    read_chk("rst_mon", ADDR_MONTH, 8'h01);
    read_chk("rst_year", ADDR_YEAR, 8'h00);
    read_chk("rst_ctrl", ADDR_CTRL, 8'h00);
    read_chk("rst_tmr_s", ADDR_TMR_S, 8'h00);
    read_chk("rst_tmr_h", ADDR_TMR_H, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
Synthesizable responder (slave) for the multiplexed address/data RTC bus (AD, CS, RD, RW, 8-bit data) that the clock controller drives as initiator. It holds BCD date/time and countdown-timer registers, advances time on an internal tick, and asserts an active-low IRQ when the timer expires. It is used as an on-board RTC substitute and as the bus-accurate model in controller system benches.

Parameters:
TICK_CYCLES, 100000000, clk cycles per one-second tick; minimum 4.
SYNC_STAGES, 2, flip-flop stages on AD/CS/RD/RW before use.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
AD  in  1  0 = address phase, 1 = data phase
CS  in  1  chip select, active-low
RD  in  1  read strobe, active-low
RW  in  1  write strobe, active-low
Dato_sal  inout  8  multiplexed address/data bus; driven only during reads
IRQ  out  1  timer interrupt, active-low, level
tick  out  1  one-cycle pulse per second tick

Behaviour:
- Reset (reset=0, asynchronous): sec/min/hour=0x00, day=0x01, month=0x01, year=0x00, timer h/m/s=0x00, ctrl=0x00, address latch=0x00, IRQ=1, Dato_sal=Z, tick=0, tick counter=0. Reset mid-transaction aborts it. No partial write occurs, and the bus is released immediately.
- Strobes are synchronized through SYNC_STAGES flops. Bus data is sampled from the final sync stage, and the initiator holds data stable across the strobe rising edge.
- Address write: synchronized RW rising edge while CS=0 and AD=0 latches Dato_sal into the address latch.
- Data write: synchronized RW rising edge while CS=0 and AD=1 writes Dato_sal to the register at the latched address. It takes effect the next cycle.
- Read: while synced CS=0, AD=1, RD=0 and RW=1, drive the register at the latched address. The drive starts SYNC_STAGES+1 cycles after RD falls and releases SYNC_STAGES+1 cycles after RD rises or CS rises.
- RD and RW both low: no drive. The write still occurs on the RW rise.
- Register map:
  - 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year.
  - 0x41 timer sec, 0x42 timer min, 0x43 timer hour.
  - 0x00 ctrl: bit0 = timer enable, bit2 = irq flag. Read returns {5'b0, flag, 1'b0, en}. Writing bit2=0 clears the flag.
  - Unmapped reads return 0x00. Unmapped writes are ignored.
- Tick: the counter counts 0..TICK_CYCLES-1, and tick pulses on wrap.
- Time increment on tick: sec 59->00 carries to min; min 59->00 carries to hour; hour 23->00 carries to day.
- Day wrap: day goes from the month length to 01 and carries to month. Month lengths are 31/30 standard; Feb is 29 when BCD year mod 4 = 0, else 28.
- Month and year wrap: month 12->01 carries to year; year 99->00.
- Out-of-range or non-BCD field values are stored as written. On their next increment they wrap to the field minimum (00, or 01 for day/month) and carry.
- BCD increment: low nibble 9->0 with +1 on the high nibble.
- Timer: when en=1 and the timer is nonzero, each tick decrements it in BCD (s 00->59 borrows from m, m 00->59 borrows from h).
  - Reaching 00:00:00 sets flag. IRQ = ~flag.
  - The timer holds at zero. A zero timer with en=1 does not re-set the flag.
- Write/tick collision: a data write coinciding with a tick defers the tick's effects (time and timer) by one cycle. The tick output is not delayed. The deferred update applies to post-write values.
- Flag set and clear in the same cycle: set wins.

Decomposition:
- Package rtc_bus_pkg holds:
  - register address constants (ADDR_SEC..ADDR_TMR_H, ADDR_CTRL);
  - ctrl bit indices;
  - reset values;
  - a month-length function taking BCD month and leap flag.
- Sub-module rtc_bcd_field: one 8-bit BCD register with load, inc and dec, a min/max input, and a carry/borrow output. It is instantiated per field and chained.
- Synchronizers and edge detect stay inline.

Test Plan:
- Write then read: address cycle 0x22, data write 0x45, then address 0x22 and read -> Dato_sal=0x45 during RD low, Z otherwise. IRQ stays 1.
- Rollover: TICK_CYCLES=4; set 1999-12-31 23:59:59 (year 0x99) -> after one tick, all fields read 00:00:00, 01/01, year 0x00.
- Leap year: year 0x24, month 0x02, day 0x28, 23:59:59 -> day 0x29. Repeat with year 0x23 -> day 0x01, month 0x03.
- Timer IRQ: timer 00:00:03, ctrl=0x01 -> IRQ falls 3 ticks later and ctrl reads 0x05. Write ctrl=0x01 -> IRQ=1.
- Collision and invalid data: write sec=0x5A on the same cycle as a tick -> after the deferred update, sec reads 0x00 and min increments. Unmapped address 0x7F reads 0x00.
- Reset mid-read: assert reset while Dato_sal is driven -> bus goes Z at once and all registers return to reset values.
